// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Common data bus arbiter. Two result producers (ALU and load/store buffer)
//   each feed a small FIFO; one queue head per cycle is granted onto the
//   registered broadcast bus.
//
//   Configuration macro: CDB_LSB_PRIORITY_EN
//     undefined (default) : round-robin between the sources when both queues
//                           hold entries; a single non-empty queue is always
//                           granted.
//     defined             : fixed priority, the LSB queue wins whenever it is
//                           non-empty; the round-robin pointer has no effect.
//
//   Ports
//     clk_in       : clock, all state changes on the rising edge
//     rst_in       : asynchronous active-low reset
//     rdy_in       : global enable; low freezes every register
//     rob_clear    : flush; empties both queues, drops the bus, rr back to ALU
//     alu_valid/alu_rob_id/alu_value/alu_new_pc : ALU result input
//     alu_ready    : ALU queue not full (registered)
//     lsb_valid/lsb_rob_id/lsb_value            : LSB result input
//     lsb_ready    : LSB queue not full (registered)
//     cdb_valid/cdb_rob_id/cdb_value/cdb_new_pc/cdb_src : broadcast bus
//                    (cdb_src 0 = ALU, 1 = LSB; cdb_new_pc is 0 for LSB)
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int ROB_W  = 4,
    parameter int QDEPTH = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             rob_clear,
    input  logic             alu_valid,
    input  logic [ROB_W-1:0] alu_rob_id,
    input  logic [31:0]      alu_value,
    input  logic [31:0]      alu_new_pc,
    output logic             alu_ready,
    input  logic             lsb_valid,
    input  logic [ROB_W-1:0] lsb_rob_id,
    input  logic [31:0]      lsb_value,
    output logic             lsb_ready,
    output logic             cdb_valid,
    output logic [ROB_W-1:0] cdb_rob_id,
    output logic [31:0]      cdb_value,
    output logic [31:0]      cdb_new_pc,
    output logic             cdb_src
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    // Queue payload storage (validity is tracked by the counters only)
    logic [ROB_W-1:0] r_alu_rob [QDEPTH];
    logic [31:0]      r_alu_val [QDEPTH];
    logic [31:0]      r_alu_pc  [QDEPTH];
    logic [ROB_W-1:0] r_lsb_rob [QDEPTH];
    logic [31:0]      r_lsb_val [QDEPTH];

    // Queue control
    logic [PW-1:0] r_alu_wp;
    logic [PW-1:0] r_alu_rp;
    logic [CW-1:0] r_alu_cnt;
    logic          r_alu_full;
    logic [PW-1:0] r_lsb_wp;
    logic [PW-1:0] r_lsb_rp;
    logic [CW-1:0] r_lsb_cnt;
    logic          r_lsb_full;
    logic          r_rr;

    // Bus registers
    logic             r_cdb_valid;
    logic [ROB_W-1:0] r_cdb_rob_id;
    logic [31:0]      r_cdb_value;
    logic [31:0]      r_cdb_new_pc;
    logic             r_cdb_src;

    // Combinational decisions
    logic          w_alu_ne;
    logic          w_lsb_ne;
    logic          w_gnt_alu;
    logic          w_gnt_lsb;
    logic          w_alu_enq;
    logic          w_lsb_enq;
    logic [CW-1:0] w_alu_cnt_nxt;
    logic [CW-1:0] w_lsb_cnt_nxt;

    // Arbitration: pick at most one non-empty queue head
    always_comb begin
        w_alu_ne  = (r_alu_cnt != {CW{1'b0}});
        w_lsb_ne  = (r_lsb_cnt != {CW{1'b0}});
        w_gnt_alu = 1'b0;
        w_gnt_lsb = 1'b0;
`ifdef CDB_LSB_PRIORITY_EN
        if (w_lsb_ne) begin
            w_gnt_lsb = 1'b1;
        end else begin
            w_gnt_alu = w_alu_ne;
        end
`else
        if (w_alu_ne && w_lsb_ne) begin
            w_gnt_alu = ~r_rr;
            w_gnt_lsb = r_rr;
        end else begin
            w_gnt_alu = w_alu_ne;
            w_gnt_lsb = w_lsb_ne;
        end
`endif
    end

    // Enqueue qualification and next occupancy (ready depends only on full)
    always_comb begin
        w_alu_enq     = alu_valid & ~r_alu_full;
        w_lsb_enq     = lsb_valid & ~r_lsb_full;
        w_alu_cnt_nxt = r_alu_cnt + {{(CW-1){1'b0}}, w_alu_enq}
                                  - {{(CW-1){1'b0}}, w_gnt_alu};
        w_lsb_cnt_nxt = r_lsb_cnt + {{(CW-1){1'b0}}, w_lsb_enq}
                                  - {{(CW-1){1'b0}}, w_gnt_lsb};
    end

    // Payload writes; a flush or stall blocks them like any other state change
    always_ff @(posedge clk_in) begin
        if (rdy_in && !rob_clear) begin
            if (w_alu_enq) begin
                r_alu_rob[r_alu_wp] <= alu_rob_id;
                r_alu_val[r_alu_wp] <= alu_value;
                r_alu_pc[r_alu_wp]  <= alu_new_pc;
            end
            if (w_lsb_enq) begin
                r_lsb_rob[r_lsb_wp] <= lsb_rob_id;
                r_lsb_val[r_lsb_wp] <= lsb_value;
            end
        end
    end

    // Queue pointers, counters, full flags, round-robin pointer and bus
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_alu_wp     <= {PW{1'b0}};
            r_alu_rp     <= {PW{1'b0}};
            r_alu_cnt    <= {CW{1'b0}};
            r_alu_full   <= 1'b0;
            r_lsb_wp     <= {PW{1'b0}};
            r_lsb_rp     <= {PW{1'b0}};
            r_lsb_cnt    <= {CW{1'b0}};
            r_lsb_full   <= 1'b0;
            r_rr         <= 1'b0;
            r_cdb_valid  <= 1'b0;
            r_cdb_rob_id <= {ROB_W{1'b0}};
            r_cdb_value  <= 32'h0000_0000;
            r_cdb_new_pc <= 32'h0000_0000;
            r_cdb_src    <= 1'b0;
        end else if (rdy_in) begin
            if (rob_clear) begin
                r_alu_wp    <= {PW{1'b0}};
                r_alu_rp    <= {PW{1'b0}};
                r_alu_cnt   <= {CW{1'b0}};
                r_alu_full  <= 1'b0;
                r_lsb_wp    <= {PW{1'b0}};
                r_lsb_rp    <= {PW{1'b0}};
                r_lsb_cnt   <= {CW{1'b0}};
                r_lsb_full  <= 1'b0;
                r_rr        <= 1'b0;
                r_cdb_valid <= 1'b0;
            end else begin
                if (w_alu_enq) begin
                    r_alu_wp <= r_alu_wp + PTR_ONE;
                end
                if (w_lsb_enq) begin
                    r_lsb_wp <= r_lsb_wp + PTR_ONE;
                end
                r_alu_cnt  <= w_alu_cnt_nxt;
                r_alu_full <= (w_alu_cnt_nxt == FULL_CNT);
                r_lsb_cnt  <= w_lsb_cnt_nxt;
                r_lsb_full <= (w_lsb_cnt_nxt == FULL_CNT);
                // rr only advances when both sources were competing
                if (w_alu_ne && w_lsb_ne) begin
                    r_rr <= ~r_rr;
                end
                if (w_gnt_alu) begin
                    r_alu_rp     <= r_alu_rp + PTR_ONE;
                    r_cdb_valid  <= 1'b1;
                    r_cdb_rob_id <= r_alu_rob[r_alu_rp];
                    r_cdb_value  <= r_alu_val[r_alu_rp];
                    r_cdb_new_pc <= r_alu_pc[r_alu_rp];
                    r_cdb_src    <= 1'b0;
                end else if (w_gnt_lsb) begin
                    r_lsb_rp     <= r_lsb_rp + PTR_ONE;
                    r_cdb_valid  <= 1'b1;
                    r_cdb_rob_id <= r_lsb_rob[r_lsb_rp];
                    r_cdb_value  <= r_lsb_val[r_lsb_rp];
                    r_cdb_new_pc <= 32'h0000_0000;
                    r_cdb_src    <= 1'b1;
                end else begin
                    r_cdb_valid  <= 1'b0;
                end
            end
        end
    end

    assign alu_ready  = ~r_alu_full;
    assign lsb_ready  = ~r_lsb_full;
    assign cdb_valid  = r_cdb_valid;
    assign cdb_rob_id = r_cdb_rob_id;
    assign cdb_value  = r_cdb_value;
    assign cdb_new_pc = r_cdb_new_pc;
    assign cdb_src    = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//   Directed bench for cdb_arbiter in its default (round-robin) build, with
//   ROB_W=4 and QDEPTH=2. Inputs change 1 time unit after a rising edge and
//   outputs are checked at that same point, i.e. they reflect the edge just
//   taken.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_clear;
    logic        alu_valid;
    logic [3:0]  alu_rob_id;
    logic [31:0] alu_value;
    logic [31:0] alu_new_pc;
    logic        alu_ready;
    logic        lsb_valid;
    logic [3:0]  lsb_rob_id;
    logic [31:0] lsb_value;
    logic        lsb_ready;
    logic        cdb_valid;
    logic [3:0]  cdb_rob_id;
    logic [31:0] cdb_value;
    logic [31:0] cdb_new_pc;
    logic        cdb_src;

    int n_tests = 0;
    int n_fail  = 0;

    cdb_arbiter #(.ROB_W(4), .QDEPTH(2)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .rob_clear  (rob_clear),
        .alu_valid  (alu_valid),
        .alu_rob_id (alu_rob_id),
        .alu_value  (alu_value),
        .alu_new_pc (alu_new_pc),
        .alu_ready  (alu_ready),
        .lsb_valid  (lsb_valid),
        .lsb_rob_id (lsb_rob_id),
        .lsb_value  (lsb_value),
        .lsb_ready  (lsb_ready),
        .cdb_valid  (cdb_valid),
        .cdb_rob_id (cdb_rob_id),
        .cdb_value  (cdb_value),
        .cdb_new_pc (cdb_new_pc),
        .cdb_src    (cdb_src)
    );

    // 10-unit clock
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_alu(input logic [3:0] rob, input logic [31:0] val);
        alu_valid  = 1'b1;
        alu_rob_id = rob;
        alu_value  = val;
        alu_new_pc = val + 32'h0000_1000;
    endtask

    task automatic push_lsb(input logic [3:0] rob, input logic [31:0] val);
        lsb_valid  = 1'b1;
        lsb_rob_id = rob;
        lsb_value  = val;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        lsb_valid = 1'b0;
    endtask

    // Check a bus beat: source, rob id, value and new_pc
    task automatic check_bus(input string tag, input logic src, input logic [3:0] rob,
                             input logic [31:0] val, input logic [31:0] pc);
        check({tag, "_valid"}, {63'd0, cdb_valid}, 64'd1);
        check({tag, "_src"},   {63'd0, cdb_src},   {63'd0, src});
        check({tag, "_rob"},   {60'd0, cdb_rob_id}, {60'd0, rob});
        check({tag, "_value"}, {32'd0, cdb_value},  {32'd0, val});
        check({tag, "_pc"},    {32'd0, cdb_new_pc}, {32'd0, pc});
    endtask

    initial begin
        rst_in     = 1'b0;
        rdy_in     = 1'b1;
        rob_clear  = 1'b0;
        alu_valid  = 1'b0;
        alu_rob_id = 4'd0;
        alu_value  = 32'd0;
        alu_new_pc = 32'd0;
        lsb_valid  = 1'b0;
        lsb_rob_id = 4'd0;
        lsb_value  = 32'd0;

        // ---------------- reset state ----------------
        #12;
        check("rst_valid", {63'd0, cdb_valid}, 64'd0);
        check("rst_rob",   {60'd0, cdb_rob_id}, 64'd0);
        check("rst_value", {32'd0, cdb_value}, 64'd0);
        check("rst_pc",    {32'd0, cdb_new_pc}, 64'd0);
        check("rst_src",   {63'd0, cdb_src}, 64'd0);
        check("rst_alu_ready", {63'd0, alu_ready}, 64'd1);
        check("rst_lsb_ready", {63'd0, lsb_ready}, 64'd1);
        rst_in = 1'b1;
        tick();

        // ---------------- single ALU result ----------------
        push_alu(4'd3, 32'h0000_0011);
        tick();                                       // enqueue edge
        idle();
        check("single_lat", {63'd0, cdb_valid}, 64'd0);
        tick();                                       // grant edge
        check_bus("single", 1'b0, 4'd3, 32'h0000_0011, 32'h0000_1011);
        tick();
        check("single_drop", {63'd0, cdb_valid}, 64'd0);

        // ---------------- contention, rr=0 -> ALU first ----------------
        push_alu(4'd1, 32'h0000_0101);
        push_lsb(4'd2, 32'h0000_0202);
        tick();
        idle();
        check("cont_lat", {63'd0, cdb_valid}, 64'd0);
        tick();                                       // rr 0 -> ALU, rr becomes 1
        check_bus("cont_alu", 1'b0, 4'd1, 32'h0000_0101, 32'h0000_1101);
        tick();                                       // LSB alone, rr stays 1
        check_bus("cont_lsb", 1'b1, 4'd2, 32'h0000_0202, 32'h0000_0000);
        tick();
        check("cont_idle", {63'd0, cdb_valid}, 64'd0);

        // ---------------- contention with rr=1 -> LSB first ----------------
        push_alu(4'd5, 32'h0000_0505);
        push_lsb(4'd6, 32'h0000_0606);
        tick();
        idle();
        tick();                                       // rr 1 -> LSB, rr becomes 0
        check_bus("rr1_lsb", 1'b1, 4'd6, 32'h0000_0606, 32'h0000_0000);
        tick();
        check_bus("rr1_alu", 1'b0, 4'd5, 32'h0000_0505, 32'h0000_1505);
        tick();
        check("rr1_idle", {63'd0, cdb_valid}, 64'd0);

        // ---------------- fill ALU queue, drop, wrap-around ----------------
        push_alu(4'd4, 32'h0000_00A0);
        push_lsb(4'd8, 32'h0000_00B0);
        tick();                                       // A: [4]    L: [8]
        lsb_valid = 1'b0;
        push_alu(4'd5, 32'h0000_00A1);
        tick();                                       // grant A4 (rr->1); A: [5]
        check_bus("fill_a0", 1'b0, 4'd4, 32'h0000_00A0, 32'h0000_10A0);
        push_alu(4'd6, 32'h0000_00A2);
        push_lsb(4'd9, 32'h0000_00B1);
        tick();                                       // grant L8 (rr->0); A: [5,6] full
        check_bus("fill_l0", 1'b1, 4'd8, 32'h0000_00B0, 32'h0000_0000);
        check("full_ready", {63'd0, alu_ready}, 64'd0);
        lsb_valid = 1'b0;
        push_alu(4'd7, 32'h0000_00A3);                // offered while full: dropped
        tick();                                       // grant A5 (rr->1); A: [6]
        check_bus("fill_a1", 1'b0, 4'd5, 32'h0000_00A1, 32'h0000_10A1);
        check("unfull_ready", {63'd0, alu_ready}, 64'd1);
        push_alu(4'd10, 32'h0000_00A4);
        tick();                                       // grant L9 (rr->0); A: [6,10]
        check_bus("fill_l1", 1'b1, 4'd9, 32'h0000_00B1, 32'h0000_0000);
        check("refull_ready", {63'd0, alu_ready}, 64'd0);
        alu_valid = 1'b0;
        tick();                                       // grant A6; A: [10]
        check_bus("fill_a2", 1'b0, 4'd6, 32'h0000_00A2, 32'h0000_10A2);
        push_alu(4'd11, 32'h0000_00A5);
        tick();                                       // grant A10; A: [11]
        check_bus("fill_a4", 1'b0, 4'd10, 32'h0000_00A4, 32'h0000_10A4);
        idle();
        tick();                                       // grant A11
        check_bus("fill_a5", 1'b0, 4'd11, 32'h0000_00A5, 32'h0000_10A5);
        tick();
        check("fill_idle", {63'd0, cdb_valid}, 64'd0);

        // ---------------- flush ----------------
        push_alu(4'd1, 32'h0000_0C01);
        push_lsb(4'd2, 32'h0000_0C02);
        tick();                                       // A: [1]   L: [2]
        push_alu(4'd3, 32'h0000_0C03);
        push_lsb(4'd4, 32'h0000_0C04);
        tick();                                       // grant A1 (rr->1); A: [3] L: [2,4]
        check("pre_flush_lsb_ready", {63'd0, lsb_ready}, 64'd0);
        rob_clear = 1'b1;                             // inputs still valid: ignored
        tick();
        rob_clear = 1'b0;
        idle();
        check("flush_valid", {63'd0, cdb_valid}, 64'd0);
        check("flush_alu_ready", {63'd0, alu_ready}, 64'd1);
        check("flush_lsb_ready", {63'd0, lsb_ready}, 64'd1);
        tick();
        check("flush_no_grant1", {63'd0, cdb_valid}, 64'd0);
        tick();
        check("flush_no_grant2", {63'd0, cdb_valid}, 64'd0);

        // rr was 1 before the flush; flush returns it to 0 -> ALU first
        push_alu(4'd9, 32'h0000_0909);
        push_lsb(4'd12, 32'h0000_0C0C);
        tick();
        idle();
        tick();                                       // grant A9 (rr->1); L: [12]
        check_bus("post_flush_alu", 1'b0, 4'd9, 32'h0000_0909, 32'h0000_1909);

        // ---------------- stall ----------------
        rdy_in = 1'b0;
        push_alu(4'd13, 32'h0000_0D0D);               // must not be taken
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", {63'd0, cdb_valid}, 64'd1);
            check("stall_rob",   {60'd0, cdb_rob_id}, 64'd9);
        end
        rdy_in = 1'b1;
        push_alu(4'd14, 32'h0000_0E0E);               // lands in empty ALU queue
        tick();                                       // grant L12 only
        alu_valid = 1'b0;
        check_bus("post_stall_lsb", 1'b1, 4'd12, 32'h0000_0C0C, 32'h0000_0000);

        // ---------------- asynchronous reset mid-cycle ----------------
        #2;
        rst_in = 1'b0;
        #1;
        check("arst_valid", {63'd0, cdb_valid}, 64'd0);
        check("arst_rob",   {60'd0, cdb_rob_id}, 64'd0);
        check("arst_value", {32'd0, cdb_value}, 64'd0);
        check("arst_src",   {63'd0, cdb_src}, 64'd0);
        check("arst_alu_ready", {63'd0, alu_ready}, 64'd1);
        rst_in = 1'b1;
        tick();                                       // queued A14 was discarded
        check("post_rst_no_grant1", {63'd0, cdb_valid}, 64'd0);
        tick();
        check("post_rst_no_grant2", {63'd0, cdb_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
